// File: rtl/load_store_unit.sv
// Data-memory access unit: byte lanes, load extension, and a valid/ready
// memory handshake that splits word-crossing accesses into two beats.
module load_store_unit #(
   parameter int DATA_WIDTH       = 32,
   parameter int ADDR_WIDTH       = 32,
   parameter int ALLOW_MISALIGNED = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [1:0]              req_size,
   input  logic                    req_sext,
   input  logic [ADDR_WIDTH-1:0]   req_address,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic                    resp_valid,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    resp_err,
   output logic                    mem_valid,
   input  logic                    mem_ready,
   output logic [ADDR_WIDTH-1:0]   mem_address,
   output logic                    mem_we,
   output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
   output logic [DATA_WIDTH-1:0]   mem_write,
   input  logic                    mem_rvalid,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OW    = $clog2(BYTES);
   localparam int IW    = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE, REQ0, RSP0, REQ1, RSP1, DONE
   } state_t;

   state_t                  state;
   logic                    we_q;
   logic                    sext_q;
   logic [1:0]              size_q;
   logic [OW-1:0]           off_q;
   logic                    cross_q;
   logic [ADDR_WIDTH-1:0]   al_q;
   logic [BYTES-1:0]        be_hi_q;
   logic [DATA_WIDTH-1:0]   wd_hi_q;
   logic [DATA_WIDTH-1:0]   rd0_q;

   logic [OW-1:0]           a_off;
   logic [3:0]              a_n;
   logic                    a_cross;
   logic                    a_ill;
   logic                    a_err;
   logic [ADDR_WIDTH-1:0]   a_al;
   logic [2*BYTES-1:0]      a_mask;
   logic [2*BYTES-1:0]      a_be2;
   logic [2*DATA_WIDTH-1:0] a_wd2;

   assign a_off   = req_address[OW-1:0];
   assign a_n     = 4'd1 << req_size;
   assign a_cross = (5'(a_off) + 5'(a_n)) > 5'(BYTES);
   assign a_ill   = (req_size == 2'd3) && (DATA_WIDTH == 32);
   assign a_err   = a_ill || (a_cross && ALLOW_MISALIGNED == 0);
   assign a_al    = {req_address[ADDR_WIDTH-1:OW], {OW{1'b0}}};

   always_comb begin
      a_mask = '0;
      for (int i = 0; i < 2*BYTES; i++)
         a_mask[i] = (i < int'(a_n));
      a_be2 = a_mask << a_off;
      a_wd2 = {{DATA_WIDTH{1'b0}}, req_wdata} << {a_off, 3'b000};
   end

   // Shift the two-beat window down, keep n bytes, extend the rest.
   function automatic logic [DATA_WIDTH-1:0] load_ext(
      input logic [2*DATA_WIDTH-1:0] raw,
      input logic [OW-1:0]           off,
      input logic [1:0]              size,
      input logic                    sext
   );
      logic [DATA_WIDTH-1:0] sh;
      logic [DATA_WIDTH-1:0] r;
      logic [IW-1:0]         top;
      logic                  fill;
      int                    nb;
      sh = DATA_WIDTH'(raw >> {off, 3'b000});
      nb = 8 << size;
      if (nb > DATA_WIDTH)
         nb = DATA_WIDTH;
      top  = IW'(nb - 1);
      fill = sext & sh[top];
      r    = sh;
      for (int i = 0; i < DATA_WIDTH; i++)
         if (i >= nb)
            r[i] = fill;
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         req_ready       <= 1'b1;
         resp_valid      <= 1'b0;
         resp_rdata      <= '0;
         resp_err        <= 1'b0;
         mem_valid       <= 1'b0;
         mem_address     <= '0;
         mem_we          <= 1'b0;
         mem_byte_enable <= '0;
         mem_write       <= '0;
         we_q            <= 1'b0;
         sext_q          <= 1'b0;
         size_q          <= '0;
         off_q           <= '0;
         cross_q         <= 1'b0;
         al_q            <= '0;
         be_hi_q         <= '0;
         wd_hi_q         <= '0;
         rd0_q           <= '0;
      end else begin
         unique case (state)
            IDLE: if (req_valid) begin
               req_ready <= 1'b0;
               we_q      <= req_we;
               sext_q    <= req_sext;
               size_q    <= req_size;
               off_q     <= a_off;
               cross_q   <= a_cross;
               al_q      <= a_al;
               be_hi_q   <= a_be2[2*BYTES-1:BYTES];
               wd_hi_q   <= a_wd2[2*DATA_WIDTH-1:DATA_WIDTH];
               rd0_q     <= '0;
               if (a_err) begin
                  state      <= DONE;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end else begin
                  state           <= REQ0;
                  mem_valid       <= 1'b1;
                  mem_address     <= a_al;
                  mem_we          <= req_we;
                  mem_byte_enable <= a_be2[BYTES-1:0];
                  mem_write       <= a_wd2[DATA_WIDTH-1:0];
               end
            end
            REQ0, REQ1: if (mem_ready) begin
               state           <= (state == REQ0) ? RSP0 : RSP1;
               mem_valid       <= 1'b0;
               mem_address     <= '0;
               mem_we          <= 1'b0;
               mem_byte_enable <= '0;
               mem_write       <= '0;
            end
            RSP0: if (mem_rvalid) begin
               rd0_q <= mem_rdata;
               if (cross_q) begin
                  state           <= REQ1;
                  mem_valid       <= 1'b1;
                  mem_address     <= al_q + ADDR_WIDTH'(BYTES);
                  mem_we          <= we_q;
                  mem_byte_enable <= be_hi_q;
                  mem_write       <= wd_hi_q;
               end else begin
                  state      <= DONE;
                  resp_valid <= 1'b1;
                  resp_rdata <= we_q ? '0 : load_ext(
                     {{DATA_WIDTH{1'b0}}, mem_rdata}, off_q, size_q, sext_q);
               end
            end
            RSP1: if (mem_rvalid) begin
               state      <= DONE;
               resp_valid <= 1'b1;
               resp_rdata <= we_q ? '0 : load_ext(
                  {mem_rdata, rd0_q}, off_q, size_q, sext_q);
            end
            DONE: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_rdata <= '0;
               resp_err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lanes, extension, splits,
// stalls, error rejection, reset abort and address wrap.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_sext = 1'b0;
   logic [31:0] req_address = '0;
   logic [31:0] req_wdata = '0;
   logic        mem_ready = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_valid, mem_we;
   logic [31:0] mem_address, mem_write;
   logic [3:0]  mem_byte_enable;

   logic        req_valid1 = 1'b0;
   logic        req_ready1, resp_valid1, resp_err1;
   logic [31:0] resp_rdata1;
   logic        mem_valid1, mem_we1;
   logic [31:0] mem_address1, mem_write1;
   logic [3:0]  mem_byte_enable1;

   int total = 0;
   int bad = 0;
   int mv1_cnt = 0;

   always #5 clk = ~clk;

   load_store_unit u0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_sext(req_sext),
      .req_address(req_address), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_address(mem_address), .mem_we(mem_we),
      .mem_byte_enable(mem_byte_enable), .mem_write(mem_write),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   load_store_unit #(.ALLOW_MISALIGNED(0)) u1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid1), .req_ready(req_ready1),
      .req_we(req_we), .req_size(req_size), .req_sext(req_sext),
      .req_address(req_address), .req_wdata(req_wdata),
      .resp_valid(resp_valid1), .resp_rdata(resp_rdata1),
      .resp_err(resp_err1),
      .mem_valid(mem_valid1), .mem_ready(1'b1),
      .mem_address(mem_address1), .mem_we(mem_we1),
      .mem_byte_enable(mem_byte_enable1), .mem_write(mem_write1),
      .mem_rvalid(1'b0), .mem_rdata(32'h0)
   );

   always @(posedge clk)
      if (mem_valid1)
         mv1_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic req(input logic we, input logic [1:0] size,
                      input logic sext, input logic [31:0] addr,
                      input logic [31:0] wd);
      req_valid   = 1'b1;
      req_we      = we;
      req_size    = size;
      req_sext    = sext;
      req_address = addr;
      req_wdata   = wd;
      step();
      req_valid = 1'b0;
   endtask

   task automatic beat(input string tag, input logic [31:0] ea,
                       input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic we, input logic [31:0] rd);
      chk({tag, ".valid"}, 32'(mem_valid), 32'd1);
      chk({tag, ".addr"}, mem_address, ea);
      chk({tag, ".be"}, 32'(mem_byte_enable), 32'(ebe));
      chk({tag, ".we"}, 32'(mem_we), 32'(we));
      if (we)
         chk({tag, ".wdata"}, mem_write, ewd);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      chk({tag, ".drop"}, 32'(mem_valid), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
   endtask

   task automatic resp(input string tag, input logic [31:0] erd,
                       input logic eerr);
      chk({tag, ".rv"}, 32'(resp_valid), 32'd1);
      chk({tag, ".rdata"}, resp_rdata, erd);
      chk({tag, ".err"}, 32'(resp_err), 32'(eerr));
      step();
      chk({tag, ".rv_off"}, 32'(resp_valid), 32'd0);
      chk({tag, ".rdata_off"}, resp_rdata, 32'd0);
      chk({tag, ".ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      step();
      step();
      chk("rst.ready", 32'(req_ready), 32'd1);
      chk("rst.mvalid", 32'(mem_valid), 32'd0);
      chk("rst.rvalid", 32'(resp_valid), 32'd0);
      chk("rst.be", 32'(mem_byte_enable), 32'd0);
      rst_n = 1'b1;
      step();

      // aligned word load, zero-wait memory
      req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      chk("lw.ready_low", 32'(req_ready), 32'd0);
      beat("lw", 32'h100, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF);
      resp("lw", 32'hDEADBEEF, 1'b0);

      req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
      beat("lb", 32'h100, 4'b1000, 32'h0, 1'b0, 32'h80000000);
      resp("lb", 32'hFFFFFF80, 1'b0);

      req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
      beat("lbu", 32'h100, 4'b1000, 32'h0, 1'b0, 32'h80000000);
      resp("lbu", 32'h00000080, 1'b0);

      // split store across the 0x4/0x8 boundary
      req(1'b1, 2'd2, 1'b0, 32'h6, 32'h11223344);
      beat("sw0", 32'h4, 4'b1100, 32'h33440000, 1'b1, 32'h0);
      beat("sw1", 32'h8, 4'b0011, 32'h00001122, 1'b1, 32'h0);
      resp("sw", 32'h0, 1'b0);

      req(1'b0, 2'd1, 1'b0, 32'h7, 32'h0);
      beat("lhu0", 32'h4, 4'b1000, 32'h0, 1'b0, 32'hAB000000);
      beat("lhu1", 32'h8, 4'b0001, 32'h0, 1'b0, 32'h000000CD);
      resp("lhu", 32'h0000CDAB, 1'b0);

      req(1'b0, 2'd1, 1'b1, 32'h7, 32'h0);
      beat("lh0", 32'h4, 4'b1000, 32'h0, 1'b0, 32'hAB000000);
      beat("lh1", 32'h8, 4'b0001, 32'h0, 1'b0, 32'h000000CD);
      resp("lh", 32'hFFFFCDAB, 1'b0);

      // illegal doubleword size on a 32-bit unit
      req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
      chk("ld.mvalid", 32'(mem_valid), 32'd0);
      resp("ld", 32'h0, 1'b1);

      // misaligned rejection on the strict instance
      req_valid1  = 1'b1;
      req_we      = 1'b0;
      req_size    = 2'd2;
      req_address = 32'h2;
      step();
      req_valid1 = 1'b0;
      chk("rej.rv", 32'(resp_valid1), 32'd1);
      chk("rej.err", 32'(resp_err1), 32'd1);
      chk("rej.rdata", resp_rdata1, 32'd0);
      step();
      chk("rej.rv_off", 32'(resp_valid1), 32'd0);
      chk("rej.ready", 32'(req_ready1), 32'd1);
      chk("rej.no_mvalid", 32'(mv1_cnt), 32'd0);

      // memory stall with a stray rvalid while in REQ0
      req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      mem_rvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall.valid", 32'(mem_valid), 32'd1);
         chk("stall.addr", mem_address, 32'h10);
         chk("stall.be", 32'(mem_byte_enable), 32'hF);
         chk("stall.rv", 32'(resp_valid), 32'd0);
      end
      mem_rvalid = 1'b0;
      beat("stall", 32'h10, 4'b1111, 32'h0, 1'b0, 32'h12345678);
      resp("stall", 32'h12345678, 1'b0);

      // reset while waiting for the read response
      req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort.ready", 32'(req_ready), 32'd1);
      chk("abort.mvalid", 32'(mem_valid), 32'd0);
      chk("abort.addr", mem_address, 32'd0);
      chk("abort.rv", 32'(resp_valid), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFEF00D;
      step();
      mem_rvalid = 1'b0;
      chk("abort.late_rv", 32'(resp_valid), 32'd0);
      step();
      chk("abort.late_rv2", 32'(resp_valid), 32'd0);
      chk("abort.rdata", resp_rdata, 32'd0);

      // second beat wraps to address zero
      req(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0);
      beat("wrap0", 32'hFFFFFFFC, 4'b1100, 32'h0, 1'b0, 32'hBBAA0000);
      beat("wrap1", 32'h00000000, 4'b0011, 32'h0, 1'b0, 32'h0000DDCC);
      resp("wrap", 32'hDDCCBBAA, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
